// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding bus master feeding a 2-entry {pc,instr} buffer.
// Optional fetch timeout watchdog enabled by defining IFETCH_TIMEOUT_EN (adds fetch_err_o).
module instr_fetch #(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [15:0] instr_addr_o,
  output logic        instr_stb_o,
  output logic        instr_we_o,
  input  logic [15:0] instr_data_i,
  input  logic        instr_ack_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_addr_i,
  input  logic        stall_i,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid_o,
`ifdef IFETCH_TIMEOUT_EN
  output logic        fetch_err_o,
`endif
  output logic [1:0]  fsm_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_KILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] kill_addr_q, kill_addr_d;

  logic [15:0] fifo_pc_q    [2];
  logic [15:0] fifo_instr_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;

  logic        stb;
  logic        ack;
  logic        pop;
  logic        push;
  logic [1:0]  count_after_pop;
  logic [1:0]  count_next;
  logic        tmo_hit;
  logic        err_blk;

  // Handshake: a bus beat completes on any edge where instr_stb_o=1 and instr_ack_i=1;
  // the buffer hands an entry to decode on any edge where instr_valid_o=1 and stall_i=0.
  // redirect_i overrides both: the buffer is flushed and nothing is pushed or popped.
  assign stb             = (state_q != S_IDLE);
  assign ack             = instr_ack_i & stb;
  assign pop             = (count_q != 2'd0) & ~stall_i & ~redirect_i;
  assign push            = (state_q == S_REQ) & ack & ~redirect_i;
  assign count_after_pop = count_q - {1'b0, pop};
  assign count_next      = count_after_pop + {1'b0, push};

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;

  // The 255th consecutive unacknowledged strobe cycle trips the watchdog.
  assign tmo_hit = stb & ~instr_ack_i & ~redirect_i & (tmo_cnt_q == 8'd254);
  assign err_blk = err_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    if (redirect_i) begin
      tmo_cnt_d = 8'd0;
      err_d     = 1'b0;
    end else if (stb && !instr_ack_i) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
      if (tmo_hit) err_d = 1'b1;
    end else if (stb) begin
      tmo_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign fetch_err_o = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err_blk = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    kill_addr_d = kill_addr_q;
    case (state_q)
      S_IDLE: begin
        if (redirect_i) begin
          addr_d  = redirect_addr_i;
          state_d = S_REQ;
        end else if ((count_after_pop < 2'd2) && !err_blk) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          if (ack) begin
            addr_d  = redirect_addr_i;
            state_d = S_REQ;
          end else begin
            kill_addr_d = redirect_addr_i;
            state_d     = S_KILL;
          end
        end else if (ack) begin
          addr_d  = addr_q + 16'd1;
          state_d = (count_next < 2'd2) ? S_REQ : S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_KILL: begin
        // The abandoned beat's data is dropped; a redirect arriving with that ack wins.
        if (ack) begin
          addr_d  = redirect_i ? redirect_addr_i : kill_addr_q;
          state_d = S_REQ;
        end else if (redirect_i) begin
          kill_addr_d = redirect_addr_i;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= RESET_ADDR;
      kill_addr_q <= RESET_ADDR;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      kill_addr_q <= kill_addr_d;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fifo_pc_q[0]    <= 16'h0000;
      fifo_pc_q[1]    <= 16'h0000;
      fifo_instr_q[0] <= 16'h0000;
      fifo_instr_q[1] <= 16'h0000;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else if (redirect_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= addr_q;
        fifo_instr_q[wr_ptr_q] <= instr_data_i;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_next;
    end
  end

  assign instr_valid_o = (count_q != 2'd0);
  assign instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : 16'h0000;
  assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : 16'h0000;
  assign instr_addr_o  = addr_q;
  assign instr_stb_o   = stb;
  assign instr_we_o    = 1'b0;
  assign fsm_state_o   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: streaming, stall back-pressure, redirect/KILL, wrap, reset.
module tb_instr_fetch;

  logic        sys_clk;
  logic        sys_rst;
  logic [15:0] instr_addr_o;
  logic        instr_stb_o;
  logic        instr_we_o;
  logic [15:0] instr_data_i;
  logic        instr_ack_i;
  logic        redirect_i;
  logic [15:0] redirect_addr_i;
  logic        stall_i;
  logic [15:0] instr_o;
  logic [15:0] instr_pc_o;
  logic        instr_valid_o;
  logic [1:0]  fsm_state_o;
`ifdef IFETCH_TIMEOUT_EN
  logic        fetch_err_o;
`endif

  localparam logic [15:0] DATA_KEY = 16'hA5A5;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;

  instr_fetch #(.RESET_ADDR(16'h0000)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .instr_addr_o    (instr_addr_o),
    .instr_stb_o     (instr_stb_o),
    .instr_we_o      (instr_we_o),
    .instr_data_i    (instr_data_i),
    .instr_ack_i     (instr_ack_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .stall_i         (stall_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_valid_o   (instr_valid_o),
`ifdef IFETCH_TIMEOUT_EN
    .fetch_err_o     (fetch_err_o),
`endif
    .fsm_state_o     (fsm_state_o)
  );

  // Memory model: each word's content is its address scrambled by a fixed key.
  assign instr_data_i = instr_addr_o ^ DATA_KEY;

  // Clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, instr_valid_o, 1'b1);
    check({tag, "_pc"}, instr_pc_o, pc);
    check({tag, "_instr"}, instr_o, pc ^ DATA_KEY);
  endtask

  initial begin
    sys_rst         = 1'b1;
    instr_ack_i     = 1'b1;
    redirect_i      = 1'b0;
    redirect_addr_i = 16'h0000;
    stall_i         = 1'b0;
    repeat (2) step();

    check("rst_stb", instr_stb_o, 1'b0);
    check("rst_valid", instr_valid_o, 1'b0);
    check("rst_addr", instr_addr_o, 16'h0000);
    check("rst_instr", instr_o, 16'h0000);
    check("rst_pc", instr_pc_o, 16'h0000);
    check("rst_state", fsm_state_o, 2'd0);
    check("rst_we", instr_we_o, 1'b0);

    // Release reset; ack is already high but must be ignored while stb is low.
    sys_rst = 1'b0;
    check("rel_stb", instr_stb_o, 1'b0);
    step();
    check("first_stb", instr_stb_o, 1'b1);
    check("first_addr", instr_addr_o, 16'h0000);
    check("first_valid", instr_valid_o, 1'b0);

    // Zero-wait streaming: pc trails address by one cycle.
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(16'(k - 1));
      step();
      exp_pc = exp_q.pop_front();
      check_head("stream", exp_pc);
      check("stream_addr", instr_addr_o, 16'(k));
    end

    // Back-pressure: buffer fills to two, strobe drops, nothing lost.
    stall_i = 1'b1;
    repeat (10) step();
    check("stall_stb", instr_stb_o, 1'b0);
    check("stall_state", fsm_state_o, 2'd0);
    check("stall_addr", instr_addr_o, 16'h0006);
    check_head("stall_head", 16'h0004);
    stall_i = 1'b0;
    step();
    check_head("unstall1", 16'h0005);
    check("unstall1_stb", instr_stb_o, 1'b1);
    check("unstall1_addr", instr_addr_o, 16'h0006);
    step();
    check_head("unstall2", 16'h0006);
    check("unstall2_addr", instr_addr_o, 16'h0007);

    // Redirect while a request waits -> KILL, stale beat dropped.
    instr_ack_i = 1'b0;
    stall_i     = 1'b1;
    step();
    step();
    check("wait_addr", instr_addr_o, 16'h0007);
    redirect_i      = 1'b1;
    redirect_addr_i = 16'h0040;
    step();
    redirect_i = 1'b0;
    check("kill_state", fsm_state_o, 2'd2);
    check("kill_valid", instr_valid_o, 1'b0);
    check("kill_stb", instr_stb_o, 1'b1);
    check("kill_addr_hold", instr_addr_o, 16'h0007);
    step();
    check("kill_wait_state", fsm_state_o, 2'd2);
    instr_ack_i = 1'b1;
    stall_i     = 1'b0;
    step();
    check("kill_exit_state", fsm_state_o, 2'd1);
    check("kill_exit_addr", instr_addr_o, 16'h0040);
    check("kill_exit_valid", instr_valid_o, 1'b0);
    step();
    check_head("after_kill", 16'h0040);
    check("after_kill_addr", instr_addr_o, 16'h0041);

    // Redirect coincident with pop and ack at occupancy 1.
    redirect_i      = 1'b1;
    redirect_addr_i = 16'h1234;
    step();
    redirect_i = 1'b0;
    check("redir_ack_valid", instr_valid_o, 1'b0);
    check("redir_ack_addr", instr_addr_o, 16'h1234);
    check("redir_ack_stb", instr_stb_o, 1'b1);
    step();
    check_head("redir_ack_head", 16'h1234);

    // Address wrap at the top of the space.
    redirect_i      = 1'b1;
    redirect_addr_i = 16'hFFFE;
    step();
    redirect_i = 1'b0;
    check("wrap_addr0", instr_addr_o, 16'hFFFE);
    step();
    check_head("wrap_a", 16'hFFFE);
    step();
    check_head("wrap_b", 16'hFFFF);
    step();
    check_head("wrap_c", 16'h0000);
    check("wrap_addr", instr_addr_o, 16'h0001);

    // A second redirect in KILL only replaces the stored restart address.
    instr_ack_i = 1'b0;
    step();
    redirect_i      = 1'b1;
    redirect_addr_i = 16'h0100;
    step();
    check("kill2_state", fsm_state_o, 2'd2);
    redirect_addr_i = 16'h0200;
    step();
    redirect_i = 1'b0;
    check("kill2_state_hold", fsm_state_o, 2'd2);
    check("kill2_addr_hold", instr_addr_o, 16'h0001);
    instr_ack_i = 1'b1;
    step();
    check("kill2_exit_addr", instr_addr_o, 16'h0200);
    check("kill2_exit_valid", instr_valid_o, 1'b0);
    step();
    check_head("kill2_head", 16'h0200);

`ifdef IFETCH_TIMEOUT_EN
    check("tmo_err_clear", fetch_err_o, 1'b0);
    instr_ack_i = 1'b0;
    repeat (254) step();
    check("tmo_stb_254", instr_stb_o, 1'b1);
    check("tmo_err_254", fetch_err_o, 1'b0);
    step();
    check("tmo_stb_255", instr_stb_o, 1'b0);
    check("tmo_err_255", fetch_err_o, 1'b1);
    repeat (3) step();
    check("tmo_stb_hold", instr_stb_o, 1'b0);
    redirect_i      = 1'b1;
    redirect_addr_i = 16'h0020;
    instr_ack_i     = 1'b1;
    step();
    redirect_i = 1'b0;
    check("tmo_err_cleared", fetch_err_o, 1'b0);
    check("tmo_resume_addr", instr_addr_o, 16'h0020);
    check("tmo_resume_stb", instr_stb_o, 1'b1);
    step();
    check_head("tmo_resume_head", 16'h0020);
`endif

    // Asynchronous reset mid-cycle abandons the request at once.
    #2;
    sys_rst = 1'b1;
    #1;
    check("async_rst_stb", instr_stb_o, 1'b0);
    check("async_rst_valid", instr_valid_o, 1'b0);
    check("async_rst_addr", instr_addr_o, 16'h0000);
    check("async_rst_pc", instr_pc_o, 16'h0000);
    check("async_rst_instr", instr_o, 16'h0000);
    check("async_rst_state", fsm_state_o, 2'd0);
    step();
    check("async_rst_hold_stb", instr_stb_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_ADDR, default 16'h0000, SHALL be the first word address fetched after reset.
REQ-002 sys_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 sys_rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 instr_addr_o  out  16  SHALL carry the instruction-memory word address.
REQ-005 instr_stb_o  out  1  SHALL be the bus request strobe.
REQ-006 instr_we_o  out  1  SHALL be the bus write enable and SHALL be constant 0.
REQ-007 instr_data_i  in  16  SHALL carry read data, valid when instr_ack_i=1.
REQ-008 instr_ack_i  in  1  SHALL be the bus acknowledge.
REQ-009 redirect_i  in  1  SHALL request a fetch-stream restart (taken branch/jump).
REQ-010 redirect_addr_i  in  16  SHALL carry the restart word address, sampled when redirect_i=1.
REQ-011 stall_i  in  1  SHALL indicate that the decode stage refuses the presented instruction.
REQ-012 instr_o  out  16  SHALL present the oldest buffered instruction.
REQ-013 instr_pc_o  out  16  SHALL present the word address of instr_o.
REQ-014 instr_valid_o  out  1  SHALL be 1 whenever instr_o/instr_pc_o are valid.

Function
REQ-015 Block SHALL contain a 2-entry FIFO of {pc,instr}; instr_valid_o = FIFO not empty; outputs driven from the head entry.
REQ-016 Pop SHALL occur on an edge where instr_valid_o=1 and stall_i=0; push SHALL occur on an edge where the state is REQ and instr_ack_i=1.
REQ-017 Simultaneous push and pop SHALL leave the occupancy unchanged and preserve order; overflow SHALL be structurally impossible.
REQ-018 FSM states SHALL be IDLE (stb=0), REQ (stb=1, awaiting ack) and KILL (stb=1, awaiting ack of an abandoned request).
REQ-019 IDLE->REQ SHALL occur when occupancy after this edge's pop is <2; otherwise remain in IDLE.
REQ-020 In REQ, instr_addr_o SHALL remain stable until ack; on ack, data SHALL be pushed with pc=instr_addr_o, the address SHALL increment by 1 (16'hFFFF wraps to 16'h0000), and the next state SHALL be REQ if post-edge occupancy <2, else IDLE.
REQ-021 instr_ack_i SHALL be ignored while instr_stb_o=0.
REQ-022 At most one request SHALL be outstanding; zero-wait ack (same cycle as stb) SHALL sustain one fetch per cycle.
REQ-023 redirect_i SHALL take priority over push, pop and ack: FIFO flushed at that edge, so instr_valid_o=0 in the next cycle.
REQ-024 Redirect in IDLE, or in REQ with ack in the same cycle, SHALL load instr_addr_o=redirect_addr_i and enter REQ.
REQ-025 Redirect in REQ without ack SHALL enter KILL, hold the old address, and store redirect_addr_i; in KILL, ack data SHALL be discarded, followed by a move to REQ at the stored address.
REQ-026 A further redirect while in KILL SHALL overwrite the stored address only.
REQ-027 Reset to first strobe SHALL be 1 cycle; ack to instr_valid_o SHALL be 1 cycle.

Reset
REQ-028 sys_rst SHALL asynchronously force: state IDLE, FIFO empty, instr_valid_o=0, instr_stb_o=0, instr_addr_o=RESET_ADDR, instr_o=0, instr_pc_o=0.
REQ-029 An outstanding bus request SHALL be abandoned by reset; an ack arriving while stb=0 after reset SHALL be ignored.

Configuration
REQ-030 With IFETCH_TIMEOUT_EN defined, the block SHALL add output fetch_err_o (1 bit) and an 8-bit counter of consecutive stb-high, ack-low cycles.
REQ-031 When that counter reaches 255, the block SHALL drop stb, set fetch_err_o (sticky) and stop fetching until redirect_i or reset.
REQ-032 Redirect or reset SHALL clear fetch_err_o and the counter.
REQ-033 Without IFETCH_TIMEOUT_EN, fetch_err_o and the counter SHALL be absent, and the block SHALL wait for ack indefinitely.

Verification
REQ-034 Scenario: release reset, RESET_ADDR=0, ack tied 1, stall 0 -> addresses 0,1,2,... one per cycle; instr_pc_o trails addr by 1 cycle.
REQ-035 Scenario: stall_i=1 for 10 cycles -> exactly 2 entries buffered, stb=0 after the 2nd ack, no loss; release -> pcs in sequence.
REQ-036 Scenario: redirect_i=1 with addr 16'h0040 while REQ waits 3 cycles for ack -> KILL; stale data dropped; next stb at 0x0040; first valid pc=0x0040.
REQ-037 Scenario: redirect together with pop and ack at occupancy 1 -> FIFO empty next cycle; fetch restarts at redirect_addr_i.
REQ-038 Scenario: start at 16'hFFFE -> pcs FFFE, FFFF, 0000.
REQ-039 Scenario: with IFETCH_TIMEOUT_EN, hold ack=0 -> stb drops and fetch_err_o=1 after 255 cycles; redirect clears it and fetch resumes.
